// File: rtl/softmax_normalizer_pkg.sv
// Shared constants and state type for the softmax normalizer stage.
package softmax_pkg;

  localparam int unsigned DEF_EXP_FRACTION_BITS = 11;
  localparam int unsigned DEF_EXP_BITS          = DEF_EXP_FRACTION_BITS + 1;
  localparam int unsigned DEF_SUM_WIDTH         = 18;
  localparam int unsigned DEF_RECIP_BITS        = 16;
  localparam int unsigned DEF_COUNT_WIDTH       = 8;

  // 1.0 in the exp / probability fixed-point format
  localparam int unsigned ONE_FIXED = 1 << DEF_EXP_FRACTION_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } norm_state_t;

endpackage

// File: rtl/softmax_normalizer_seq_divider.sv
// Generic restoring divider: one quotient bit per cycle, DIVIDEND_WIDTH cycles after i_start.
// The final quotient is presented combinationally in the cycle o_done_c is high.
module seq_divider #(
  parameter int unsigned DIVIDEND_WIDTH = 28,
  parameter int unsigned DIVISOR_WIDTH  = 18
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic                      i_start,
  input  logic [DIVIDEND_WIDTH-1:0] i_dividend,
  input  logic [DIVISOR_WIDTH-1:0]  i_divisor,
  output logic                      o_done_c,
  output logic [DIVIDEND_WIDTH-1:0] o_quotient_c
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_WIDTH - 1);

  logic [DIVIDEND_WIDTH-1:0] r_dvd;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic [DIVIDEND_WIDTH-2:0] r_quot;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;

  logic [DIVISOR_WIDTH:0]    w_trial;
  logic                      w_ge;
  logic [DIVISOR_WIDTH-1:0]  w_rem_nxt;
  logic [DIVIDEND_WIDTH-1:0] w_quot_nxt;

  // Shift in the next dividend bit and try subtracting the divisor
  assign w_trial    = {r_rem, r_dvd[DIVIDEND_WIDTH-1]};
  assign w_ge       = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nxt  = w_ge ? DIVISOR_WIDTH'(w_trial - {1'b0, r_dvs}) : DIVISOR_WIDTH'(w_trial);
  assign w_quot_nxt = {r_quot, w_ge};

  assign o_done_c     = r_busy && (r_cnt == LAST);
  assign o_quotient_c = w_quot_nxt;

  // Iteration registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_dvd  <= i_dividend;
      r_dvs  <= i_divisor;
      r_rem  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd  <= {r_dvd[DIVIDEND_WIDTH-2:0], 1'b0};
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt[DIVIDEND_WIDTH-2:0];
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/softmax_normalizer.sv
// Softmax normalizer: reciprocal of the exp sum, then p_j = e_j * (1/sum) over valid/ready.
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int unsigned SUM_WIDTH         = DEF_SUM_WIDTH,
  parameter int unsigned EXP_FRACTION_BITS = DEF_EXP_FRACTION_BITS,
  parameter int unsigned EXP_BITS          = EXP_FRACTION_BITS + 1,
  parameter int unsigned RECIP_BITS        = DEF_RECIP_BITS,
  parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   start,
  input  logic [SUM_WIDTH-1:0]   sum_in,
  input  logic [COUNT_WIDTH-1:0] num_elems,
  output logic                   busy,
  output logic                   done,
  output logic                   div_err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_BITS-1:0]    e_zj_zmax,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_BITS-1:0]    prob
);

  localparam int unsigned DIV_W  = RECIP_BITS + EXP_FRACTION_BITS + 1;
  localparam int unsigned RCP_W  = RECIP_BITS + 1;
  localparam int unsigned PROD_W = EXP_BITS + RCP_W;
  localparam int unsigned SCL_W  = PROD_W - RECIP_BITS;

  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(1) << (DIV_W - 1);
  localparam logic [SCL_W-1:0] ONE_SCL  = SCL_W'(1) << EXP_FRACTION_BITS;

  norm_state_t            r_state, w_state_nxt;
  logic [COUNT_WIDTH-1:0] r_num, w_num_nxt;
  logic [COUNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [RCP_W-1:0]       r_recip, w_recip_nxt;
  logic [EXP_BITS-1:0]    r_prob, w_prob_nxt;
  logic                   r_out_valid, w_out_valid_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_div_err, w_div_err_nxt;
  logic                   r_busy;

  logic                   w_in_ready;
  logic                   w_div_start;
  logic                   w_div_done;
  logic [DIV_W-1:0]       w_quot;
  logic [RCP_W-1:0]       w_recip_sat;
  logic [PROD_W-1:0]      w_prod;
  logic [SCL_W-1:0]       w_scaled;
  logic [EXP_BITS-1:0]    w_prob_sat;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;
  logic                   w_out_hs;

  seq_divider #(
    .DIVIDEND_WIDTH (DIV_W),
    .DIVISOR_WIDTH  (SUM_WIDTH)
  ) u_div (
    .clk          (clk),
    .rst_         (rst_),
    .i_start      (w_div_start),
    .i_dividend   (DIVIDEND),
    .i_divisor    (sum_in),
    .o_done_c     (w_div_done),
    .o_quotient_c (w_quot)
  );

  // Sums below 1.0 would overflow the reciprocal; clamp to all ones
  assign w_recip_sat = (|w_quot[DIV_W-1:RCP_W]) ? '1 : w_quot[RCP_W-1:0];

  // Scale the exp value by the reciprocal, truncate, saturate at 1.0
  assign w_prod     = PROD_W'(e_zj_zmax) * PROD_W'(r_recip);
  assign w_scaled   = w_prod[PROD_W-1:RECIP_BITS];
  assign w_prob_sat = (w_scaled > ONE_SCL) ? EXP_BITS'(ONE_SCL) : w_scaled[EXP_BITS-1:0];

  assign w_cnt_inc = r_cnt + COUNT_WIDTH'(1);
  assign w_out_hs  = r_out_valid && out_ready;

  // Next-state and register-next computation
  always_comb begin
    w_state_nxt     = r_state;
    w_num_nxt       = r_num;
    w_cnt_nxt       = r_cnt;
    w_recip_nxt     = r_recip;
    w_prob_nxt      = r_prob;
    w_out_valid_nxt = r_out_valid;
    w_done_nxt      = 1'b0;
    w_div_err_nxt   = 1'b0;
    w_in_ready      = 1'b0;
    w_div_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_num_nxt = num_elems;
          w_cnt_nxt = '0;
          if (sum_in == '0) begin
            w_recip_nxt   = '1;
            w_div_err_nxt = 1'b1;
            if (num_elems == '0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = STREAM;
            end
          end else begin
            w_div_start = 1'b1;
            w_state_nxt = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (w_div_done) begin
          w_recip_nxt = w_recip_sat;
          if (r_num == '0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        w_in_ready = !r_out_valid || out_ready;
        if (w_out_hs) begin
          w_out_valid_nxt = 1'b0;
        end
        if (in_valid && w_in_ready) begin
          w_prob_nxt      = w_prob_sat;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = w_cnt_inc;
          if (w_cnt_inc == r_num) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_out_hs) begin
          w_out_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= IDLE;
      r_num       <= '0;
      r_cnt       <= '0;
      r_recip     <= '0;
      r_prob      <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_div_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_num       <= w_num_nxt;
      r_cnt       <= w_cnt_nxt;
      r_recip     <= w_recip_nxt;
      r_prob      <= w_prob_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_done      <= w_done_nxt;
      r_div_err   <= w_div_err_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign div_err   = r_div_err;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign prob      = r_prob;

endmodule

// File: doc/softmax_normalizer.md
Name: softmax_normalizer

Overview:
- Consumes the softmax denominator Σ exp(z_j − z_max) produced by the running-sum accumulator.
- Computes its fixed-point reciprocal with a sequential restoring divider.
- Then streams the same exp(z_j − z_max) values back in and emits normalized probabilities p_j = e_j / Σ over a valid/ready interface.
- Sits between the accumulator/exp-buffer stage and the softmax output port.

Parameters:
- SUM_WIDTH, 18, width of the incoming denominator (EXP_FRACTION_BITS fractional bits).
- EXP_FRACTION_BITS, 11, fractional bits of exp values and of output probabilities.
- EXP_BITS, EXP_FRACTION_BITS+1, width of exp input and probability output (1 integer + fraction).
- RECIP_BITS, 16, fractional bits of the internal reciprocal.
- COUNT_WIDTH, 8, width of the element counter.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches sum_in and num_elems (honoured only in IDLE)
- sum_in  in  SUM_WIDTH  Σ exp(z_j − z_max) from accumulator
- num_elems  in  COUNT_WIDTH  number of elements to normalize
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the last probability is accepted downstream
- div_err  out  1  one-cycle pulse, sum_in == 0 at start
- in_valid  in  1  e_zj_zmax input valid
- in_ready  out  1  normalizer accepts e_zj_zmax
- e_zj_zmax  in  EXP_BITS  exp(z_j − z_max), unsigned
- out_valid  out  1  prob valid
- out_ready  in  1  downstream accepts prob
- prob  out  EXP_BITS  normalized probability, unsigned, EXP_FRACTION_BITS fraction

Behaviour:
- Reset (async, rst_ low): state=IDLE; busy, done, div_err, in_ready, out_valid = 0; prob=0; counter, reciprocal and divider registers cleared. Reset mid-operation aborts without emitting done.
- Let D = RECIP_BITS+EXP_FRACTION_BITS+1 (28 default).
- Reciprocal r = floor(2^(RECIP_BITS+EXP_FRACTION_BITS) / sum). r is held in RECIP_BITS+1 bits, so r ≤ 2^RECIP_BITS when sum ≥ 1.0.
- IDLE:
  - On start: latch sum, num_elems, clear the counter.
  - If sum == 0: r = all ones, pulse div_err the next cycle, go to STREAM (or IDLE with done if num_elems == 0).
  - Otherwise go to DIVIDE.
  - start in any other state is ignored.
- DIVIDE: restoring division, one quotient bit per cycle, exactly D cycles. The dividend is the constant 2^(RECIP_BITS+EXP_FRACTION_BITS). After the last bit, r is registered. If num_elems == 0: pulse done, go to IDLE; else go to STREAM.
- STREAM:
  - in_ready = !out_valid || out_ready.
  - Input handshake (in_valid && in_ready): prob <= min((e_zj_zmax * r) >> RECIP_BITS, 2^EXP_FRACTION_BITS). The product is EXP_BITS+RECIP_BITS+1 wide, result is truncated, and saturates at 1.0.
  - On handshake, out_valid <= 1 and the counter increments.
  - Single-stage registered output, 1-cycle latency, full throughput under out_ready=1.
  - prob is held stable while out_valid && !out_ready.
  - When the num_elems-th input is accepted: in_ready drops, go to DRAIN.
- DRAIN: in_ready = 0. When out_valid && out_ready: out_valid <= 0, pulse done, go to IDLE.
- Output handshake with no new input: out_valid <= 0.
- Counter wraps are impossible: transfers stop at num_elems. in_valid outside STREAM is ignored.

Decomposition:
- Shared package softmax_pkg:
  - EXP_FRACTION_BITS, EXP_BITS, SUM_WIDTH, RECIP_BITS defaults.
  - ONE_FIXED = 2^EXP_FRACTION_BITS.
  - State enum norm_state_t {IDLE, DIVIDE, STREAM, DRAIN}.
- Sub-module seq_divider: a generic restoring divider with start/done, DIVIDEND_WIDTH/DIVISOR_WIDTH parameters and a D-cycle latency. It is reusable elsewhere in the engine; the FSM, multiplier and handshake stay in the top.

Test Plan:
- Divider and full-scale element: sum_in=2048 (1.0), num_elems=1, e=2048.
  - r=65536 after exactly 28 DIVIDE cycles.
  - prob=2048, out_valid one cycle after the input handshake, then done.
- Equal elements: sum_in=4096, num_elems=2, e=2048,2048 → r=32768, prob=1024,1024.
- Truncation: sum_in=6144, num_elems=3, e=2048 each → r=21845, prob=682 ×3, done after the third output accept.
- Backpressure: out_ready low 5 cycles mid-stream → prob stable, in_ready=0 while out_valid && !out_ready, no loss/duplication; 8-element random stream matches the golden model.
- Error and empty cases:
  - sum_in=0 → div_err pulse, r=all ones, prob saturates to 2048.
  - num_elems=0 → done after DIVIDE, no out_valid.
  - start while busy is ignored.
- Reset mid-DIVIDE and mid-STREAM → all outputs 0, state IDLE, next start runs cleanly.
